// File: rtl/loss_feeder.sv
`default_nettype none
// ============================================================================
// Module   : loss_feeder
// Purpose  : Pairs buffered ground-truth labels (Y) with streaming network
//            outputs (H) and frames each batch for the loss child.
// Options  : LOSS_FEEDER_ERR_CHECK_EN builds the sticky protocol-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module loss_feeder #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          y_wr_en,
    input  logic [15:0]                   y_wr_data,
    output logic                          y_full,
    output logic [$clog2(FIFO_DEPTH):0]   y_count,
    input  logic                          h_valid,
    input  logic [15:0]                   h_data,
    output logic                          h_ready,
    input  logic                          cfg_start,
    input  logic [CNT_W-1:0]              cfg_batch_size,
    input  logic [15:0]                   cfg_inv_two_over_n,
    output logic [15:0]                   H_out,
    output logic [15:0]                   Y_out,
    output logic                          valid_out,
    output logic [15:0]                   inv_batch_size_times_two_out,
    output logic                          busy,
    output logic                          done,
    output logic                          err_out
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   batch_q, batch_d;
    logic [15:0]        inv_q, inv_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [15:0]        h_out_q, h_out_d;
    logic [15:0]        y_out_q, y_out_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [15:0]        mem_q [FIFO_DEPTH];

    logic               fifo_empty;
    logic               fifo_full;
    logic               in_run;
    logic               xfer;
    logic               push;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_run     = (state_q == ST_RUN);
    assign xfer       = in_run && h_valid && !fifo_empty;
    // A pop in the same cycle frees a slot, so a push onto a full FIFO lands.
    assign push       = y_wr_en && (!fifo_full || xfer);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        batch_d  = batch_q;
        inv_d    = inv_q;
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(xfer);
        h_out_d  = h_out_q;
        y_out_d  = y_out_q;
        valid_d  = xfer;

        if (xfer) begin
            h_out_d = h_data;
            y_out_d = mem_q[rd_ptr_q[AW-1:0]];
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    batch_d = cfg_batch_size;
                    inv_d   = cfg_inv_two_over_n;
                    cnt_d   = '0;
                    state_d = (cfg_batch_size == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == batch_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            batch_q  <= '0;
            inv_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            h_out_q  <= '0;
            y_out_q  <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            batch_q  <= batch_d;
            inv_q    <= inv_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            h_out_q  <= h_out_d;
            y_out_q  <= y_out_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Storage carries no reset; clearing the pointers discards its contents.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= y_wr_data;
        end
    end

`ifdef LOSS_FEEDER_ERR_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (y_wr_en && fifo_full && !xfer) begin
            err_d = 1'b1;
        end
        if (h_valid && in_run && fifo_empty) begin
            err_d = 1'b1;
        end
        if (h_valid && (state_q == ST_IDLE)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_out = err_q;
`else
    assign err_out = 1'b0;
`endif

    assign y_full                       = fifo_full;
    assign y_count                      = wr_ptr_q - rd_ptr_q;
    assign h_ready                      = in_run && !fifo_empty;
    assign H_out                        = h_out_q;
    assign Y_out                        = y_out_q;
    assign valid_out                    = valid_q;
    assign inv_batch_size_times_two_out = inv_q;
    assign busy                         = busy_q;
    assign done                         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_loss_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_loss_feeder
// Purpose  : Directed and randomized bench for loss_feeder against a
//            queue-based behavioural model of the batch feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_loss_feeder;

    localparam int DEPTH = 16;
    localparam int CW    = 16;
    localparam int AW    = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              y_wr_en = 1'b0;
    logic [15:0]       y_wr_data = '0;
    logic              y_full;
    logic [AW:0]       y_count;
    logic              h_valid = 1'b0;
    logic [15:0]       h_data = '0;
    logic              h_ready;
    logic              cfg_start = 1'b0;
    logic [CW-1:0]     cfg_batch_size = '0;
    logic [15:0]       cfg_inv_two_over_n = '0;
    logic [15:0]       H_out;
    logic [15:0]       Y_out;
    logic              valid_out;
    logic [15:0]       inv_out;
    logic              busy;
    logic              done;
    logic              err_out;

    loss_feeder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .y_wr_en                      (y_wr_en),
        .y_wr_data                    (y_wr_data),
        .y_full                       (y_full),
        .y_count                      (y_count),
        .h_valid                      (h_valid),
        .h_data                       (h_data),
        .h_ready                      (h_ready),
        .cfg_start                    (cfg_start),
        .cfg_batch_size               (cfg_batch_size),
        .cfg_inv_two_over_n           (cfg_inv_two_over_n),
        .H_out                        (H_out),
        .Y_out                        (Y_out),
        .valid_out                    (valid_out),
        .inv_batch_size_times_two_out (inv_out),
        .busy                         (busy),
        .done                         (done),
        .err_out                      (err_out)
    );

    always #5 clk = ~clk;

    // Behavioural model: label queue plus batch bookkeeping.
    logic [15:0] m_q[$];
    int          m_phase;      // 0 waiting, 1 collecting pairs, 2 batch end
    int          m_pairs;
    int          m_n;
    logic [15:0] m_inv;
    logic [15:0] m_h;
    logic [15:0] m_y;
    bit          m_valid;
    bit          m_err;
    bit          m_chk_data;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit we, input logic [15:0] wd,
                        input bit hv, input logic [15:0] hd,
                        input bit st, input int n, input logic [15:0] inv);
        bit ready, xfer, was_full;
        rst                = r;
        y_wr_en            = we;
        y_wr_data          = wd;
        h_valid            = hv;
        h_data             = hd;
        cfg_start          = st;
        cfg_batch_size     = CW'(n);
        cfg_inv_two_over_n = inv;
        #1;
        ready = (m_phase == 1) && (m_q.size() > 0);
        chk("h_ready", 32'(h_ready), 32'(ready));

        m_chk_data = 1'b0;
        if (!r) begin
            m_q.delete();
            m_phase = 0; m_pairs = 0; m_n = 0;
            m_inv = '0; m_h = '0; m_y = '0;
            m_valid = 1'b0; m_err = 1'b0;
            m_chk_data = 1'b1;
        end else begin
            xfer     = ready && hv;
            was_full = (m_q.size() == DEPTH);
            if (we && was_full && !xfer) m_err = 1'b1;
            if (hv && m_phase == 1 && m_q.size() == 0) m_err = 1'b1;
            if (hv && m_phase == 0) m_err = 1'b1;
            m_valid = xfer;
            if (xfer) begin
                m_h = hd;
                m_y = m_q.pop_front();
                m_chk_data = 1'b1;
            end
            if (we && (!was_full || xfer)) m_q.push_back(wd);
            case (m_phase)
                0: if (st) begin
                       m_n = n; m_inv = inv; m_pairs = 0;
                       m_phase = (n == 0) ? 2 : 1;
                   end
                1: if (xfer) begin
                       m_pairs++;
                       if (m_pairs == m_n) m_phase = 2;
                   end
                default: m_phase = 0;
            endcase
        end

        @(posedge clk);
        #1;
        chk("valid_out", 32'(valid_out), 32'(m_valid));
        chk("done", 32'(done), 32'(m_phase == 2));
        chk("busy", 32'(busy), 32'(m_phase == 1));
        chk("y_count", 32'(y_count), 32'(m_q.size()));
        chk("y_full", 32'(y_full), 32'(m_q.size() == DEPTH));
        chk("inv_out", 32'(inv_out), 32'(m_inv));
`ifdef LOSS_FEEDER_ERR_CHECK_EN
        chk("err_out", 32'(err_out), 32'(m_err));
`else
        chk("err_out", 32'(err_out), 32'(0));
`endif
        if (m_chk_data) begin
            chk("H_out", 32'(H_out), 32'(m_h));
            chk("Y_out", 32'(Y_out), 32'(m_y));
        end
    endtask

    task automatic idle();
        step(1, 0, '0, 0, '0, 0, 0, '0);
    endtask

    task automatic push(input logic [15:0] v);
        step(1, 1, v, 0, '0, 0, 0, '0);
    endtask

    initial begin
        m_phase = 0; m_pairs = 0; m_n = 0;
        m_inv = '0; m_h = '0; m_y = '0;
        m_valid = 0; m_err = 0; m_chk_data = 0;

        // Reset state
        for (int i = 0; i < 3; i++) step(0, 0, '0, 0, '0, 0, 0, '0);

        // Preloaded labels, N=4 streamed back to back
        for (int i = 0; i < 4; i++) push(16'h0100 * 16'(i + 1));
        step(1, 0, '0, 0, '0, 1, 4, 16'h0080);
        for (int i = 0; i < 4; i++) step(1, 0, '0, 1, 16'h0180 + 16'h0100 * 16'(i), 0, 0, '0);
        idle(); idle();

        // Label underrun, then a late label
        step(1, 0, '0, 0, '0, 1, 3, 16'h0055);
        step(1, 0, '0, 1, 16'h1111, 0, 0, '0);
        step(1, 0, '0, 1, 16'h1111, 0, 0, '0);
        step(1, 1, 16'h0aaa, 1, 16'h1111, 0, 0, '0);
        step(1, 0, '0, 1, 16'h1112, 0, 0, '0);
        idle();
        push(16'h0bbb); push(16'h0ccc);
        step(1, 0, '0, 1, 16'h1113, 0, 0, '0);
        step(1, 0, '0, 1, 16'h1114, 0, 0, '0);
        idle(); idle();

        // Full FIFO, dropped push, push+pop while full
        for (int i = 0; i < DEPTH; i++) push(16'($urandom));
        push(16'hdead);
        step(1, 0, '0, 0, '0, 1, DEPTH + 1, 16'h000d);
        step(1, 1, 16'hbeef, 1, 16'h2000, 0, 0, '0);
        for (int i = 0; i < DEPTH; i++) step(1, 0, '0, 1, 16'($urandom), 0, 0, '0);
        idle(); idle();

        // Zero batch, then a start ignored in RUN
        step(1, 0, '0, 0, '0, 1, 0, 16'h0033);
        idle(); idle();
        push(16'h0101); push(16'h0202);
        step(1, 0, '0, 0, '0, 1, 2, 16'h0011);
        step(1, 0, '0, 0, '0, 1, 5, 16'h0022);
        step(1, 0, '0, 1, 16'h3001, 0, 0, '0);
        step(1, 0, '0, 1, 16'h3002, 0, 0, '0);
        idle(); idle();

        // Reset mid-batch, then a fresh batch
        for (int i = 0; i < 4; i++) push(16'($urandom));
        step(1, 0, '0, 0, '0, 1, 4, 16'h0080);
        step(1, 0, '0, 1, 16'h4001, 0, 0, '0);
        step(1, 0, '0, 1, 16'h4002, 0, 0, '0);
        step(0, 0, '0, 1, 16'h4003, 0, 0, '0);
        idle(); idle();
        push(16'h0505); push(16'h0606);
        step(1, 0, '0, 0, '0, 1, 2, 16'h0100);
        step(1, 0, '0, 1, 16'h5001, 0, 0, '0);
        step(1, 0, '0, 1, 16'h5002, 0, 0, '0);
        idle(); idle();

        // h_valid toggling every other cycle, N=6
        for (int i = 0; i < 6; i++) push(16'($urandom));
        step(1, 0, '0, 0, '0, 1, 6, 16'h0055);
        for (int i = 0; i < 12; i++) step(1, 0, '0, (i % 2) == 0, 16'($urandom), 0, 0, '0);
        idle(); idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) != 0), $urandom_range(0, 1), 16'($urandom),
                 ($urandom_range(0, 2) != 0), 16'($urandom),
                 ($urandom_range(0, 9) == 0), $urandom_range(0, 5), 16'($urandom));
        end
        idle(); idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/loss_feeder.md
# loss_feeder

Streaming source for the loss stage. Buffers ground-truth labels (Y) in a small FIFO, pairs each with an incoming network output (H) under valid/ready flow control, and drives aligned `H`, `Y`, `valid` and the batch scale `2/N` (Q8.8) into a loss child. It counts pairs per batch, frames the batch with start/done, and sits between the activation output stream and the loss children.

## Interface
Parameters:
- `FIFO_DEPTH`, default 16: label FIFO entries; must be a power of two ≥ 2.
- `CNT_W`, default 16: width of the batch-size register and pair counter.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `y_wr_en`  in  1  push `y_wr_data` into the label FIFO.
- `y_wr_data`  in  16  signed Q8.8 label.
- `y_full`  out  1  label FIFO full.
- `y_count`  out  $clog2(FIFO_DEPTH)+1  label FIFO occupancy.
- `h_valid`  in  1  `h_data` is valid.
- `h_data`  in  16  signed Q8.8 network output.
- `h_ready`  out  1  H accepted this cycle when `h_valid` is also high.
- `cfg_start`  in  1  single-cycle pulse that begins a batch.
- `cfg_batch_size`  in  CNT_W  number of pairs in the batch; sampled on `cfg_start`.
- `cfg_inv_two_over_n`  in  16  signed Q8.8 value of 2/N; sampled on `cfg_start`.
- `H_out`  out  16  signed H to the loss child.
- `Y_out`  out  16  signed Y to the loss child.
- `valid_out`  out  1  `H_out`/`Y_out` are valid.
- `inv_batch_size_times_two_out`  out  16  latched 2/N for the loss child.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse at batch end.
- `err_out`  out  1  sticky error flag (see Configuration).

## Operation
- FSM states:
  - IDLE: waits for `cfg_start`; ignores H.
  - RUN: accepts pairs.
  - DONE: lasts one cycle, then IDLE.
- IDLE + `cfg_start`:
  - Latch `cfg_batch_size` and `cfg_inv_two_over_n`.
  - Clear the pair counter.
  - Go to RUN, or to DONE if `cfg_batch_size` is 0.
- `cfg_start` in RUN or DONE is ignored.
- In RUN, `h_ready` = FIFO not empty, combinational. A pair transfers when `h_valid && h_ready`: pop one Y and increment the counter.
- When the counter reaches the latched batch size on a transfer, go to DONE. `h_ready` is 0 outside RUN.
- Label FIFO: circular, read/write pointers with an extra wrap bit.
  - Push while full is dropped, except when a pop occurs the same cycle; then the push is accepted.
  - Push while empty with no pop: normal.
  - The FIFO accepts pushes in every state, so labels can be preloaded in IDLE.
- H and Y are passed through unmodified; no arithmetic on data.
- `inv_batch_size_times_two_out` holds the latched value until the next accepted `cfg_start`.
- Reset (`rst`=0) clears the FSM to IDLE, the FIFO pointers (contents discarded), the counter, and all outputs.

## Timing
- Reset values: `H_out`, `Y_out`, `inv_batch_size_times_two_out` = 0. `valid_out`, `done`, `busy`, `err_out`, `y_full` = 0. `y_count` = 0. `h_ready` = 0.
- Latency: a transfer in cycle t gives `valid_out`=1 with that H/Y in cycle t+1. `valid_out` is low in any cycle after no transfer.
- Throughput: one pair per cycle while H is valid and labels are available.
- `done` is registered and rises in the same cycle as `valid_out` for the last pair. It is high exactly for the one cycle the FSM spends in DONE.
- Zero batch: `done` rises 1 cycle after `cfg_start`; `valid_out` never asserts.
- `busy` = (state == RUN), registered.
- `y_full` and `y_count` reflect the registered FIFO state, updated 1 cycle after a push/pop.
- Reset mid-batch: no further `valid_out` or `done` is generated, starting the cycle after `rst` is sampled low.

## Configuration
- `LOSS_FEEDER_ERR_CHECK_EN` defined:
  - `err_out` sets and stays set until reset on any of:
    - a dropped push (push while full, no pop);
    - `h_valid` high in RUN while the FIFO is empty (label underrun);
    - `h_valid` high in IDLE.
  - It rises 1 cycle after the offending cycle.
- Not defined: no check logic is built and `err_out` is tied to 0. Data behaviour is identical in both builds.

## Test plan
- Preload Y = 0x0100, 0x0200, 0x0300, 0x0400. Then `cfg_start` with N=4, 2/N=0x0080, and hold `h_valid` with H = 0x0180, 0x0280, 0x0380, 0x0480 → four consecutive `valid_out` cycles with matching pairs, `inv_batch_size_times_two_out`=0x0080, `done` on the 4th output cycle, then `busy`=0.
- Start N=3 with an empty FIFO and H valid → `h_ready`=0, no output. Push one label → one pair out 1 cycle after the transfer. With ERR_CHECK_EN, `err_out`=1.
- Fill 16 labels, push a 17th → `y_full`=1, `y_count`=16, and the 17th is dropped. Push+pop in the same cycle while full → count stays 16 and the new label appears after 15 further pops.
- `cfg_start` with N=0 → `done` the next cycle, `valid_out` stays 0. A second `cfg_start` while in RUN does not change the latched N.
- Drop `rst` low after 2 of 4 pairs → next cycle `busy`=0, `y_count`=0, `valid_out`=0, no `done`. A fresh batch runs normally afterwards.
- Toggle `h_valid` every other cycle with N=6 → six outputs, each exactly 1 cycle after its transfer, in order, with `done` aligned to the 6th.
